// File: rtl/msrv32_wr_en_ctrl_pipe.sv
// Registered writeback write-enable controller: flush/stall/drain gating, x0 suppression
// and saturating per-channel commit counters for NUM_CH write ports.

module msrv32_wr_en_ctrl_ch #(
    parameter int ADDR_W   = 12,
    parameter int CNT_W    = 16,
    parameter bit ZERO_SUP = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              gate_i,
    input  logic              stall_i,
    input  logic              cnt_clr_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [CNT_W-1:0]  cnt_o
);
    logic              pass;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [CNT_W-1:0]  cnt_q;

    assign pass = req_i & ~gate_i & ~(ZERO_SUP & (addr_i == '0));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            wr_en_q <= pass;
            if (!stall_i)
                wr_addr_q <= addr_i;
            // Counts the enable already on the output, so it trails the commit by a cycle.
            if (cnt_clr_i)
                cnt_q <= '0;
            else if (wr_en_q && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign cnt_o     = cnt_q;
endmodule

module msrv32_wr_en_ctrl_pipe #(
    parameter int                NUM_CH       = 2,
    parameter int                ADDR_W       = 12,
    parameter int                DRAIN_CYCLES = 2,
    parameter logic [NUM_CH-1:0] ZERO_MASK    = NUM_CH'(1),
    parameter int                CNT_W        = 16
) (
    input  logic                    ms_riscv32_mp_clk_in,
    input  logic                    ms_riscv32_mp_rst_n_in,
    input  logic                    flush_in,
    input  logic                    stall_in,
    input  logic [NUM_CH-1:0]       wr_en_req_in,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr_in,
    input  logic                    cnt_clr_in,
    output logic [NUM_CH-1:0]       wr_en_out,
    output logic [NUM_CH*ADDR_W-1:0] wr_addr_out,
    output logic                    drain_busy_out,
    output logic [NUM_CH*CNT_W-1:0] commit_cnt_out
);
    localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           gate;

    logic [NUM_CH-1:0][ADDR_W-1:0] addr_in_a, addr_out_a;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_a;

    // A flush reloads rather than extends the window; a stall freezes it.
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (flush_in)
            drain_cnt_d = DCW'(DRAIN_CYCLES);
        else if (!stall_in && (drain_cnt_q != '0))
            drain_cnt_d = drain_cnt_q - DCW'(1);
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in)
            drain_cnt_q <= '0;
        else
            drain_cnt_q <= drain_cnt_d;
    end

    assign gate           = flush_in | stall_in | (drain_cnt_q != '0);
    assign drain_busy_out = (drain_cnt_q != '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign addr_in_a[i] = wr_addr_in[i*ADDR_W +: ADDR_W];

        msrv32_wr_en_ctrl_ch #(
            .ADDR_W   (ADDR_W),
            .CNT_W    (CNT_W),
            .ZERO_SUP (ZERO_MASK[i])
        ) u_ch (
            .clk_i     (ms_riscv32_mp_clk_in),
            .rst_n_i   (ms_riscv32_mp_rst_n_in),
            .req_i     (wr_en_req_in[i]),
            .addr_i    (addr_in_a[i]),
            .gate_i    (gate),
            .stall_i   (stall_in),
            .cnt_clr_i (cnt_clr_in),
            .wr_en_o   (wr_en_out[i]),
            .wr_addr_o (addr_out_a[i]),
            .cnt_o     (cnt_a[i])
        );

        assign wr_addr_out[i*ADDR_W +: ADDR_W]  = addr_out_a[i];
        assign commit_cnt_out[i*CNT_W +: CNT_W] = cnt_a[i];
    end
endmodule
